// File: rtl/display_pkg.sv
// ============================================================================
// Module  : display_pkg
// Brief   : Shared state encoding and debounce default for display_capture.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [0:0] {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  // 10 ms of stable key at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module  : key_debounce
// Brief   : Synchronizer, optional debounce filter (DISPLAY_CAPTURE_DEBOUNCE_EN)
//           and falling-edge press detector for an active-low pushbutton.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic tecla,
  output logic press
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level_d;
  logic       r_armed;
  logic [1:0] r_prime;
  logic       w_level;

  // r_prime marks when r_sync2 holds a real key sample rather than its reset value;
  // a press is only honoured once a genuine released level has been accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level_d <= 1'b1;
      r_armed   <= 1'b0;
      r_prime   <= 2'b00;
    end else begin
      r_sync1   <= tecla;
      r_sync2   <= r_sync1;
      r_level_d <= w_level;
      r_prime   <= {r_prime[0], 1'b1};
      if (r_prime[1] && r_sync2 && w_level) begin
        r_armed <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_CAPTURE_DEBOUNCE_EN
  localparam int unsigned c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [c_DB_W-1:0] r_cnt;
  logic              r_level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  assign press = r_armed & r_level_d & ~w_level;

endmodule

`default_nettype wire

// File: rtl/display_capture.sv
// ============================================================================
// Module  : display_capture
// Brief   : Live/frozen capture of datapath results for the 7-segment display,
//           with dropped-update counter. Debounce via DISPLAY_CAPTURE_DEBOUNCE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module display_capture
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      dado,
  input  logic             zero_in,
  input  logic             valido,
  input  logic             tecla,
  output logic [31:0]      entrada,
  output logic             zero,
  output logic             congelado,
  output logic [CNT_W-1:0] perdidos
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_entrada;
  logic [31:0]        w_entrada_nxt;
  logic               r_zero;
  logic               w_zero_nxt;
  logic [CNT_W-1:0]   r_perdidos;
  logic [CNT_W-1:0]   w_perdidos_nxt;
  logic               r_congelado;
  logic               w_press;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clock (clock),
    .reset (reset),
    .tecla (tecla),
    .press (w_press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= LIVE;
      r_entrada   <= '0;
      r_zero      <= 1'b0;
      r_perdidos  <= '0;
      r_congelado <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_entrada   <= w_entrada_nxt;
      r_zero      <= w_zero_nxt;
      r_perdidos  <= w_perdidos_nxt;
      r_congelado <= (w_state_nxt == FROZEN);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_entrada_nxt  = r_entrada;
    w_zero_nxt     = r_zero;
    w_perdidos_nxt = r_perdidos;
    case (r_state)
      LIVE: begin
        if (valido) begin
          w_entrada_nxt = dado;
          w_zero_nxt    = zero_in;
        end
        if (w_press) begin
          w_state_nxt    = FROZEN;
          w_perdidos_nxt = '0;
        end
      end
      FROZEN: begin
        // Updates arriving while frozen are only counted, never shown
        if (valido && (r_perdidos != {CNT_W{1'b1}})) begin
          w_perdidos_nxt = r_perdidos + 1'b1;
        end
        if (w_press) begin
          w_state_nxt = LIVE;
        end
      end
      default: w_state_nxt = LIVE;
    endcase
  end

  assign entrada   = r_entrada;
  assign zero      = r_zero;
  assign congelado = r_congelado;
  assign perdidos  = r_perdidos;

endmodule

`default_nettype wire

// File: tb/tb_display_capture.sv
// ============================================================================
// Module  : tb_display_capture
// Brief   : Directed self-checking bench for display_capture (DEBOUNCE_CYCLES=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_display_capture;

  localparam int unsigned c_DEB   = 4;
  localparam int unsigned c_CNT_W = 8;
`ifdef DISPLAY_CAPTURE_DEBOUNCE_EN
  // edge at which a press pulse is consumed, counted from the edge after tecla falls
  localparam int c_PRESS_LAT = 7;
`else
  localparam int c_PRESS_LAT = 3;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [31:0]        dado = '0;
  logic               zero_in = 1'b0;
  logic               valido = 1'b0;
  logic               tecla = 1'b1;
  logic [31:0]        entrada;
  logic               zero;
  logic               congelado;
  logic [c_CNT_W-1:0] perdidos;

  int checks   = 0;
  int failures = 0;

  display_capture #(
    .DEBOUNCE_CYCLES (c_DEB),
    .CNT_W           (c_CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .dado      (dado),
    .zero_in   (zero_in),
    .valido    (valido),
    .tecla     (tecla),
    .entrada   (entrada),
    .zero      (zero),
    .congelado (congelado),
    .perdidos  (perdidos)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press_release(input string tag, input logic exp_cong);
    tecla = 1'b0;
    tick(10);
    check({tag, "_pressed"}, {31'b0, congelado}, {31'b0, exp_cong});
    tecla = 1'b1;
    tick(10);
    check({tag, "_released"}, {31'b0, congelado}, {31'b0, exp_cong});
  endtask

  initial begin
    tick(3);
    check("rst_entrada", entrada, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);
    check("rst_congelado", {31'b0, congelado}, 32'h0);
    check("rst_perdidos", {24'b0, perdidos}, 32'h0);
    reset = 1'b1;
    tick(4);

    // live capture
    valido = 1'b1; dado = 32'hDEADBEEF; zero_in = 1'b0;
    tick(1);
    valido = 1'b0;
    check("live_entrada", entrada, 32'hDEADBEEF);
    check("live_zero", {31'b0, zero}, 32'h0);
    check("live_congelado", {31'b0, congelado}, 32'h0);

    // freeze, then drop three updates
    press_release("freeze1", 1'b1);
    for (int i = 0; i < 3; i++) begin
      valido = 1'b1; dado = 32'h12345678;
      tick(1);
      valido = 1'b0;
      tick(1);
    end
    check("frozen_entrada", entrada, 32'hDEADBEEF);
    check("frozen_perdidos3", {24'b0, perdidos}, 32'd3);

    // saturation
    valido = 1'b1;
    tick(300);
    valido = 1'b0;
    tick(1);
    check("sat_perdidos", {24'b0, perdidos}, 32'd255);
    press_release("unfreeze_sat", 1'b0);
    check("live_keeps_perdidos", {24'b0, perdidos}, 32'd255);
    press_release("refreeze", 1'b1);
    check("refreeze_clears", {24'b0, perdidos}, 32'd0);

    // press coincident with valido while FROZEN
    tecla = 1'b0;
    tick(c_PRESS_LAT - 1);
    valido = 1'b1; dado = 32'hCAFEF00D; zero_in = 1'b1;
    tick(1);
    valido = 1'b0;
    check("coin_frz_congelado", {31'b0, congelado}, 32'h0);
    check("coin_frz_perdidos", {24'b0, perdidos}, 32'd1);
    check("coin_frz_entrada", entrada, 32'hDEADBEEF);
    tecla = 1'b1;
    tick(10);

    // press coincident with valido while LIVE
    tecla = 1'b0;
    tick(c_PRESS_LAT - 1);
    valido = 1'b1; dado = 32'h00000000; zero_in = 1'b1;
    tick(1);
    valido = 1'b0; zero_in = 1'b0;
    check("coin_live_entrada", entrada, 32'h0);
    check("coin_live_zero", {31'b0, zero}, 32'h1);
    check("coin_live_congelado", {31'b0, congelado}, 32'h1);
    check("coin_live_perdidos", {24'b0, perdidos}, 32'd0);
    tecla = 1'b1;
    tick(10);

`ifdef DISPLAY_CAPTURE_DEBOUNCE_EN
    // bounce shorter than the filter window must be ignored
    for (int i = 0; i < 10; i++) begin
      tecla = 1'b0;
      tick(2);
      tecla = 1'b1;
      tick(2);
    end
    tick(10);
    check("bounce_no_press", {31'b0, congelado}, 32'h1);
`else
    // single-cycle low: press consumed at the third edge
    tecla = 1'b0;
    tick(1);
    tecla = 1'b1;
    tick(1);
    check("raw_press_lat2", {31'b0, congelado}, 32'h1);
    tick(1);
    check("raw_press_lat3", {31'b0, congelado}, 32'h0);
    tick(5);
`endif

    // reset with key held: no press after release of reset
    tecla = 1'b0;
    reset = 1'b0;
    tick(3);
    check("rst2_congelado", {31'b0, congelado}, 32'h0);
    check("rst2_entrada", entrada, 32'h0);
    check("rst2_zero", {31'b0, zero}, 32'h0);
    check("rst2_perdidos", {24'b0, perdidos}, 32'd0);
    reset = 1'b1;
    tick(15);
    check("held_no_press", {31'b0, congelado}, 32'h0);
    tecla = 1'b1;
    tick(10);
    check("held_release_no_press", {31'b0, congelado}, 32'h0);
    press_release("rearmed", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
